ifetch_prefetch: RTL and testbench



---
 rtl/ifetch_prefetch_pkg.sv | 21 ++
 rtl/ifetch_prefetch_sync_fifo.sv | 46 ++++
 rtl/ifetch_prefetch.sv | 111 +++++++++++
 tb/tb_ifetch_prefetch.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_prefetch_pkg.sv
// Shared fetch-path definitions: default widths, the NOP encoding, and the
// stall-level decode that ctrl uses to derive hold_i.
package ifetch_prefetch_pkg;

  localparam int          ADDR_W_DEF = 32;
  localparam int          INST_W_DEF = 32;
  localparam logic [31:0] NOP_INST   = 32'h0000_0013;

  typedef enum logic [1:0] {
    HOLD_NONE = 2'd0,
    HOLD_PC   = 2'd1,
    HOLD_IF   = 2'd2,
    HOLD_ID   = 2'd3
  } hold_lvl_e;

  // The ID output stage stalls for IF-level holds and anything stronger.
  function automatic logic hold_if_stage(hold_lvl_e lvl);
    return (lvl == HOLD_IF) || (lvl == HOLD_ID);
  endfunction

endpackage

// File: rtl/ifetch_prefetch_sync_fifo.sv
// Small synchronous FIFO with a single-cycle flush and an occupancy count.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         wr_en,
  input  logic [WIDTH-1:0]             wr_data,
  input  logic                         rd_en,
  output logic [WIDTH-1:0]             rd_data,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(wr_en) - CW'(rd_en);
    end
  end

  always_ff @(posedge clk)
    if (wr_en) mem[wr_ptr] <= wr_data;

  assign rd_data = mem[rd_ptr];

  // Credit accounting upstream guarantees neither condition can occur.
  always_ff @(posedge clk)
    if (!rst && !flush) begin
      assert (!(wr_en && !rd_en && count == CW'(DEPTH))) else $error("sync_fifo overflow");
      assert (!(rd_en && count == '0)) else $error("sync_fifo underflow");
    end

endmodule

// File: rtl/ifetch_prefetch.sv
// Instruction fetch with prefetch queue: sequential requests under a credit
// limit, in-order responses, stall without loss, redirect discarding stale data.
module ifetch_prefetch
  import ifetch_prefetch_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter int                INST_W   = INST_W_DEF,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [INST_W-1:0] NOP      = INST_W'(NOP_INST)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              jtag_reset_i,
  input  logic              jump_flag_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  input  logic              hold_i,
  output logic              req_valid_o,
  output logic [ADDR_W-1:0] req_addr_o,
  input  logic              req_ready_i,
  input  logic              rsp_valid_i,
  input  logic [INST_W-1:0] rsp_data_i,
  output logic              inst_valid_o,
  output logic [INST_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_addr_o
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int QW = ADDR_W + INST_W;

  logic              rst_any;
  logic [ADDR_W-1:0] pc, tag;
  logic [CW-1:0]     outst, drop, qcnt;
  logic [CW+1:0]     used;
  logic              accept, rsp_live, q_empty, bypass, q_wr, q_rd;
  logic [QW-1:0]     q_head;
  logic              unused_jaddr_lo;

  assign rst_any         = rst | jtag_reset_i;
  assign unused_jaddr_lo = ^jump_addr_i[1:0];

  // Stale responses still occupy memory-side slots, so they consume credit.
  assign used        = (CW+2)'(outst) + (CW+2)'(drop) + (CW+2)'(qcnt);
  assign req_valid_o = ~rst_any & ~jump_flag_i & (used < (CW+2)'(DEPTH));
  assign req_addr_o  = pc;
  assign accept      = req_valid_o & req_ready_i;

  assign rsp_live = rsp_valid_i & (drop == '0);
  assign q_empty  = (qcnt == '0);
  assign bypass   = rsp_live & ~hold_i & q_empty;
  assign q_wr     = rsp_live & ~bypass;
  assign q_rd     = ~hold_i & ~q_empty;

  // Tag FIFO occupancy is exactly the live outstanding request count.
  sync_fifo #(.WIDTH(ADDR_W), .DEPTH(DEPTH)) u_tag_fifo (
    .clk     (clk),
    .rst     (rst_any),
    .flush   (jump_flag_i),
    .wr_en   (accept),
    .wr_data (pc),
    .rd_en   (rsp_live),
    .rd_data (tag),
    .count   (outst)
  );

  sync_fifo #(.WIDTH(QW), .DEPTH(DEPTH)) u_inst_q (
    .clk     (clk),
    .rst     (rst_any),
    .flush   (jump_flag_i),
    .wr_en   (q_wr),
    .wr_data ({tag, rsp_data_i}),
    .rd_en   (q_rd),
    .rd_data (q_head),
    .count   (qcnt)
  );

  always_ff @(posedge clk) begin
    if (rst_any) begin
      pc           <= RESET_PC;
      drop         <= '0;
      inst_valid_o <= 1'b0;
      inst_addr_o  <= '0;
      inst_o       <= NOP;
    end else if (jump_flag_i) begin
      pc           <= {jump_addr_i[ADDR_W-1:2], 2'b00};
      drop         <= drop + outst - CW'(rsp_valid_i);
      inst_valid_o <= 1'b0;
      inst_addr_o  <= '0;
      inst_o       <= NOP;
    end else begin
      if (accept) pc <= pc + ADDR_W'(4);
      drop <= drop - CW'(rsp_valid_i & ~rsp_live);
      if (!hold_i) begin
        if (!q_empty) begin
          inst_valid_o <= 1'b1;
          inst_addr_o  <= q_head[QW-1:INST_W];
          inst_o       <= q_head[INST_W-1:0];
        end else if (rsp_live) begin
          inst_valid_o <= 1'b1;
          inst_addr_o  <= tag;
          inst_o       <= rsp_data_i;
        end else begin
          inst_valid_o <= 1'b0;
          inst_addr_o  <= '0;
          inst_o       <= NOP;
        end
      end
    end
  end

endmodule

// File: tb/tb_ifetch_prefetch.sv
// Directed bench for ifetch_prefetch with a queue-based reference model and a
// 1-cycle memory whose data is a fixed function of the address.
module tb_ifetch_prefetch;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] NOPV     = 32'h0000_0013;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst, jtag_reset_i, jump_flag_i, hold_i, req_ready_i, rsp_valid_i;
  logic [31:0] jump_addr_i, rsp_data_i;
  logic        req_valid_o, inst_valid_o;
  logic [31:0] req_addr_o, inst_o, inst_addr_o;

  always #5 clk = ~clk;

  ifetch_prefetch #(.ADDR_W(32), .INST_W(32), .DEPTH(DEPTH), .RESET_PC(RESET_PC), .NOP(NOPV)) dut (
    .clk          (clk),
    .rst          (rst),
    .jtag_reset_i (jtag_reset_i),
    .jump_flag_i  (jump_flag_i),
    .jump_addr_i  (jump_addr_i),
    .hold_i       (hold_i),
    .req_valid_o  (req_valid_o),
    .req_addr_o   (req_addr_o),
    .req_ready_i  (req_ready_i),
    .rsp_valid_i  (rsp_valid_i),
    .rsp_data_i   (rsp_data_i),
    .inst_valid_o (inst_valid_o),
    .inst_o       (inst_o),
    .inst_addr_o  (inst_addr_o)
  );

  int checks = 0, failures = 0;

  // Model: every request in flight (stale or not), and every received but
  // not yet delivered instruction.
  typedef struct { logic [31:0] addr; bit stale; } fl_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; } ent_t;
  fl_t         fl[$];
  ent_t        q[$];
  logic [31:0] m_pc, m_a, m_d;
  bit          m_v, started = 0;

  function automatic logic [31:0] mem_data(logic [31:0] a);
    return a ^ 32'h5A00_0000;
  endfunction

  function automatic bit exp_req_valid();
    return !rst && !jtag_reset_i && !jump_flag_i && (fl.size() + q.size() < DEPTH);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    bit   acc, live;
    fl_t  e;
    ent_t n;
    acc  = exp_req_valid() && req_ready_i;
    live = 0;
    if (rst || jtag_reset_i) begin
      m_pc = RESET_PC; fl.delete(); q.delete();
      m_v = 0; m_a = 0; m_d = NOPV;
    end else begin
      if (rsp_valid_i) begin
        e    = fl.pop_front();
        live = !e.stale;
      end
      if (jump_flag_i) begin
        for (int i = 0; i < fl.size(); i++) begin
          e = fl[i]; e.stale = 1; fl[i] = e;
        end
        q.delete();
        m_pc = {jump_addr_i[31:2], 2'b00};
        m_v = 0; m_a = 0; m_d = NOPV;
      end else begin
        if (acc) begin
          fl.push_back('{m_pc, 1'b0});
          m_pc = m_pc + 32'd4;
        end
        if (live) q.push_back('{e.addr, rsp_data_i});
        if (!hold_i) begin
          if (q.size() > 0) begin
            n = q.pop_front(); m_v = 1; m_a = n.addr; m_d = n.data;
          end else begin
            m_v = 0; m_a = 0; m_d = NOPV;
          end
        end
      end
    end
    started = 1;
  end

  always @(negedge clk)
    if (started) begin
      chk("inst_valid", 32'(inst_valid_o), 32'(m_v));
      chk("inst_addr", inst_addr_o, m_a);
      chk("inst", inst_o, m_d);
      chk("req_valid", 32'(req_valid_o), 32'(exp_req_valid()));
      if (exp_req_valid()) chk("req_addr", req_addr_o, m_pc);
    end

  // One cycle of stimulus; the memory answers the oldest request in flight.
  task automatic cyc(bit r, bit jr, bit j, logic [31:0] ja, bit h, bit rdy, bit ren);
    @(posedge clk); #1;
    rst = r; jtag_reset_i = jr; jump_flag_i = j; jump_addr_i = ja;
    hold_i = h; req_ready_i = rdy;
    rsp_valid_i = ren && (fl.size() > 0);
    rsp_data_i  = rsp_valid_i ? mem_data(fl[0].addr) : 32'hDEAD_BEEF;
    #2;
  endtask

  task automatic run(int n, bit h, bit rdy, bit ren);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 32'h0, h, rdy, ren);
  endtask

  initial begin
    bit found;
    rst = 1; jtag_reset_i = 0; jump_flag_i = 0; jump_addr_i = 0;
    hold_i = 0; req_ready_i = 0; rsp_valid_i = 0; rsp_data_i = 0;

    cyc(1, 0, 0, 0, 0, 1, 1);
    chk("rst_inst_valid", 32'(inst_valid_o), 32'd0);
    chk("rst_inst", inst_o, NOPV);
    chk("rst_inst_addr", inst_addr_o, 32'd0);
    chk("rst_req_valid", 32'(req_valid_o), 32'd0);
    cyc(1, 0, 0, 0, 0, 1, 1);

    // Streaming, then a 10-cycle hold while 0x10 is on the output.
    for (int k = 1; k <= 19; k++) begin
      cyc(0, 0, 0, 0, (k >= 7 && k <= 16), 1, 1);
      if (k == 1) begin
        chk("first_req_valid", 32'(req_valid_o), 32'd1);
        chk("first_req_addr", req_addr_o, RESET_PC);
      end
      if (k == 3) begin
        chk("first_inst_valid", 32'(inst_valid_o), 32'd1);
        chk("first_inst_addr", inst_addr_o, 32'h0);
        chk("first_inst", inst_o, 32'h5A00_0000);
      end
      if (k == 4)  chk("second_inst_addr", inst_addr_o, 32'h4);
      if (k == 12) chk("hold_frozen", inst_addr_o, 32'h10);
      if (k == 16) chk("hold_no_req", 32'(req_valid_o), 32'd0);
      if (k == 18) chk("hold_resume", inst_addr_o, 32'h14);
      if (k == 19) chk("hold_next", inst_addr_o, 32'h18);
    end

    // Memory stops accepting: everything drains, request stays pending.
    run(8, 0, 0, 1);
    chk("drain_inst_valid", 32'(inst_valid_o), 32'd0);
    chk("drain_req_valid", 32'(req_valid_o), 32'd1);

    // Three requests left without responses, then redirect to 0x103.
    run(3, 0, 1, 0);
    cyc(0, 0, 1, 32'h103, 0, 1, 0);
    chk("jump_no_req", 32'(req_valid_o), 32'd0);
    cyc(0, 0, 0, 0, 0, 1, 1);
    chk("jump_req_addr", req_addr_o, 32'h100);
    chk("jump_inst_invalid", 32'(inst_valid_o), 32'd0);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      cyc(0, 0, 0, 0, 0, 1, 1);
      if (inst_valid_o) found = 1;
    end
    chk("jump_first_seen", 32'(found), 32'd1);
    if (found) chk("jump_first_addr", inst_addr_o, 32'h100);

    // Jump together with hold and a response: jump wins.
    run(4, 0, 1, 1);
    cyc(0, 0, 1, 32'h200, 1, 1, 1);
    cyc(0, 0, 0, 0, 0, 1, 1);
    chk("jh_inst_invalid", 32'(inst_valid_o), 32'd0);
    chk("jh_req_addr", req_addr_o, 32'h200);
    run(6, 0, 1, 1);

    // Address wrap at the top of the space.
    cyc(0, 0, 1, 32'hFFFF_FFFC, 0, 1, 1);
    cyc(0, 0, 0, 0, 0, 1, 1);
    chk("wrap_req_top", req_addr_o, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 0, 0, 1, 1);
    chk("wrap_req_zero", req_addr_o, 32'h0);
    run(8, 0, 1, 1);

    // Debug reset in mid-stream.
    cyc(0, 1, 0, 0, 0, 1, 1);
    chk("jrst_req_valid", 32'(req_valid_o), 32'd0);
    cyc(0, 0, 0, 0, 0, 1, 1);
    chk("jrst_inst_valid", 32'(inst_valid_o), 32'd0);
    chk("jrst_inst", inst_o, NOPV);
    chk("jrst_inst_addr", inst_addr_o, 32'd0);
    chk("jrst_req_addr", req_addr_o, RESET_PC);
    chk("jrst_req_valid2", 32'(req_valid_o), 32'd1);
    run(6, 0, 1, 1);

    @(posedge clk); #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
